lfsr_gen: RTL and testbench

Parametrised pseudo-random sequence generator; successor to the fixed 5-bit LFSR. Width, tap polynomial, feedback topology (Fibonacci or Galois) and steps-per-advance are set by parameters. Adds clock enable, run-time seed load, all-zero lock-up recovery and period measurement. It feeds test-pattern, scrambler and random-address logic in the datapath.

---
 rtl/lfsr_pkg.sv | 60 ++++++
 rtl/lfsr_step_unit.sv | 19 +
 rtl/lfsr_gen.sv | 140 ++++++++++++++
 tb/tb_lfsr_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, maximal-length tap masks and the single-step function for
// the parametrised LFSR generator.
package lfsr_pkg;

  typedef enum logic {
    FIBONACCI = 1'b0,
    GALOIS    = 1'b1
  } lfsr_mode_e;

  // Maximal-length tap masks for the right-shifting Fibonacci form
  // (bit i set means state bit i feeds the XOR). The reciprocal of each is
  // also primitive, so the same masks give full-length Galois sequences.
  localparam logic [2:0]  TAPS_N3  = 3'h3;
  localparam logic [3:0]  TAPS_N4  = 4'h3;
  localparam logic [4:0]  TAPS_N5  = 5'h05;
  localparam logic [5:0]  TAPS_N6  = 6'h03;
  localparam logic [6:0]  TAPS_N7  = 7'h03;
  localparam logic [7:0]  TAPS_N8  = 8'h1D;
  localparam logic [8:0]  TAPS_N9  = 9'h011;
  localparam logic [9:0]  TAPS_N10 = 10'h009;
  localparam logic [10:0] TAPS_N11 = 11'h005;
  localparam logic [11:0] TAPS_N12 = 12'h941;
  localparam logic [12:0] TAPS_N13 = 13'h1601;
  localparam logic [13:0] TAPS_N14 = 14'h2A01;
  localparam logic [14:0] TAPS_N15 = 15'h0003;
  localparam logic [15:0] TAPS_N16 = 16'h100B;
  localparam logic [16:0] TAPS_N17 = 17'h00009;
  localparam logic [17:0] TAPS_N18 = 18'h00081;
  localparam logic [18:0] TAPS_N19 = 19'h62001;
  localparam logic [19:0] TAPS_N20 = 20'h00009;
  localparam logic [20:0] TAPS_N21 = 21'h000005;
  localparam logic [21:0] TAPS_N22 = 22'h000003;
  localparam logic [22:0] TAPS_N23 = 23'h000021;
  localparam logic [23:0] TAPS_N24 = 24'h000087;
  localparam logic [24:0] TAPS_N25 = 25'h0000009;
  localparam logic [25:0] TAPS_N26 = 26'h3100001;
  localparam logic [26:0] TAPS_N27 = 27'h6400001;
  localparam logic [27:0] TAPS_N28 = 28'h0000009;
  localparam logic [28:0] TAPS_N29 = 29'h00000005;
  localparam logic [29:0] TAPS_N30 = 30'h25000001;
  localparam logic [30:0] TAPS_N31 = 31'h00000009;
  localparam logic [31:0] TAPS_N32 = 32'hC0000401;

  // One LFSR step on a zero-extended state of the given width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input lfsr_mode_e  mode,
                                            input int unsigned width);
    logic        fb;
    logic [31:0] next;
    fb = ^(state & taps);
    if (mode == FIBONACCI) begin
      next = (state >> 1) | ({31'd0, fb} << (width - 1));
    end else begin
      next = (state >> 1) ^ (state[0] ? taps : 32'd0);
    end
    return next;
  endfunction

endpackage

// File: rtl/lfsr_step_unit.sv
// Combinational single LFSR step plus a compare against the origin state,
// chained STEPS deep by the top level.
module lfsr_step_unit
  import lfsr_pkg::*;
#(
  parameter int         N    = 5,
  parameter logic [N-1:0] TAPS = N'(5'b00101),
  parameter lfsr_mode_e MODE = FIBONACCI
) (
  input  logic [N-1:0] state_i,
  input  logic [N-1:0] origin_i,
  output logic [N-1:0] state_o,
  output logic         hit_o
);

  assign state_o = N'(lfsr_step(32'(state_i), 32'(TAPS), MODE, N));
  assign hit_o   = (state_o == origin_i);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with clock enable, seed load, all-zero
// lock-up recovery and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int           N     = 5,
  parameter logic [N-1:0] TAPS  = N'(5'b00101),
  parameter int           MODE  = 0,
  parameter int           STEPS = 1,
  parameter logic [N-1:0] INIT  = N'(1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] q,
  output logic         wrap,
  output logic         lockup,
  output logic [N-1:0] count,
  output logic [N-1:0] period
);

  localparam lfsr_mode_e MODE_E = (MODE == 1) ? GALOIS : FIBONACCI;

  if (N < 3 || N > 32) begin : g_bad_n
    $error("lfsr_gen: N must be in 3..32");
  end
  if (STEPS < 1 || STEPS > N) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..N");
  end
  if (INIT == '0) begin : g_bad_init
    $error("lfsr_gen: INIT must be non-zero");
  end

  logic [N-1:0] q_q, q_d;
  logic [N-1:0] origin_q, origin_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] period_q, period_d;
  logic         wrap_q, wrap_d;
  logic         lockup_q, lockup_d;

  // Step chain: chain[k] is the state after k single steps.
  logic [N-1:0] chain [0:STEPS];
  logic [STEPS-1:0] hit;
  logic         hit_found;
  int           hit_idx;

  assign chain[0] = q_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_step_unit #(
      .N    (N),
      .TAPS (TAPS),
      .MODE (MODE_E)
    ) u_step (
      .state_i  (chain[i]),
      .origin_i (origin_q),
      .state_o  (chain[i+1]),
      .hit_o    (hit[i])
    );
  end

  // Locate the earliest step within this advance that lands on origin.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = 0;
    for (int i = STEPS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_found = 1'b1;
        hit_idx   = i;
      end
    end
  end

  // Next-state selection: load beats en beats hold; lock-up beats wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    q_d      = q_q;
    origin_d = origin_q;
    count_d  = count_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      count_d = '0;
      if (seed != '0) begin
        q_d      = seed;
        origin_d = seed;
      end else begin
        q_d      = INIT;
        origin_d = INIT;
        lockup_d = 1'b1;
      end
    end else if (en) begin
      if (chain[STEPS] == '0) begin
        q_d      = origin_q;
        count_d  = '0;
        lockup_d = 1'b1;
      end else if (hit_found) begin
        q_d      = chain[STEPS];
        wrap_d   = 1'b1;
        period_d = count_q + N'(hit_idx + 1);
        count_d  = N'(STEPS - hit_idx - 1);
      end else begin
        q_d     = chain[STEPS];
        count_d = count_q + N'(STEPS);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q      <= INIT;
      origin_q <= INIT;
      count_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      q_q      <= q_d;
      origin_q <= origin_d;
      count_q  <= count_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign q      = q_q;
  assign count  = count_q;
  assign period = period_q;
  assign wrap   = wrap_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench: four lfsr_gen configurations share one stimulus
// stream; each is compared every cycle against an arithmetic model, with
// directed checks on the published sequences and boundary cases.
module tb_lfsr_gen;

  localparam int NI = 4;  // 0 fib default, 1 galois, 2 three-step, 3 zero taps

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] seed = 5'd0;

  logic [4:0] q_o      [NI];
  logic [4:0] count_o  [NI];
  logic [4:0] period_o [NI];
  logic       wrap_o   [NI];
  logic       lockup_o [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_gen u_fib (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .q(q_o[0]), .wrap(wrap_o[0]), .lockup(lockup_o[0]),
    .count(count_o[0]), .period(period_o[0]));

  lfsr_gen #(.MODE(1), .TAPS(5'b10100)) u_gal (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .q(q_o[1]), .wrap(wrap_o[1]), .lockup(lockup_o[1]),
    .count(count_o[1]), .period(period_o[1]));

  lfsr_gen #(.STEPS(3)) u_ms (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .q(q_o[2]), .wrap(wrap_o[2]), .lockup(lockup_o[2]),
    .count(count_o[2]), .period(period_o[2]));

  lfsr_gen #(.TAPS(5'b00000)) u_zero (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .q(q_o[3]), .wrap(wrap_o[3]), .lockup(lockup_o[3]),
    .count(count_o[3]), .period(period_o[3]));

  // Reference model: plain arithmetic on 5-bit values.
  typedef struct {
    int          mode;
    int unsigned taps;
    int          steps;
    int unsigned q, origin, count, period;
    bit          wrap, lockup;
  } mdl_t;

  mdl_t  mdl [NI];
  string names [NI] = '{"fib", "gal", "ms3", "zero"};

  function automatic int unsigned ref_step(int unsigned s, int unsigned taps, int mode);
    if (mode == 0) return (s / 2) + (($countones(s & taps) % 2) * 16);
    return (s / 2) ^ ((s % 2 == 1) ? taps : 0);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NI; m++) begin
      mdl[m].q = 1; mdl[m].origin = 1; mdl[m].count = 0; mdl[m].period = 0;
      mdl[m].wrap = 0; mdl[m].lockup = 0;
    end
  endtask

  task automatic model_edge(input bit ld, input bit e, input int unsigned sd);
    int unsigned s;
    int          hit_at;
    for (int m = 0; m < NI; m++) begin
      mdl[m].wrap = 0;
      mdl[m].lockup = 0;
      if (ld) begin
        mdl[m].count = 0;
        if (sd != 0) begin
          mdl[m].q = sd; mdl[m].origin = sd;
        end else begin
          mdl[m].q = 1; mdl[m].origin = 1; mdl[m].lockup = 1;
        end
      end else if (e) begin
        s = mdl[m].q;
        hit_at = 0;
        for (int k = 1; k <= mdl[m].steps; k++) begin
          s = ref_step(s, mdl[m].taps, mdl[m].mode);
          if (hit_at == 0 && s == mdl[m].origin) hit_at = k;
        end
        if (s == 0) begin
          mdl[m].q = mdl[m].origin; mdl[m].count = 0; mdl[m].lockup = 1;
        end else if (hit_at != 0) begin
          mdl[m].q = s; mdl[m].wrap = 1;
          mdl[m].period = (mdl[m].count + hit_at) % 32;
          mdl[m].count = mdl[m].steps - hit_at;
        end else begin
          mdl[m].q = s;
          mdl[m].count = (mdl[m].count + mdl[m].steps) % 32;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ph);
    for (int m = 0; m < NI; m++) begin
      check({ph, "/", names[m], "/q"},      32'(q_o[m]),      mdl[m].q);
      check({ph, "/", names[m], "/count"},  32'(count_o[m]),  mdl[m].count);
      check({ph, "/", names[m], "/period"}, 32'(period_o[m]), mdl[m].period);
      check({ph, "/", names[m], "/wrap"},   32'(wrap_o[m]),   32'(mdl[m].wrap));
      check({ph, "/", names[m], "/lockup"}, 32'(lockup_o[m]), 32'(mdl[m].lockup));
    end
  endtask

  // One clock: inputs already driven; sample #1 after the edge.
  task automatic cycle(input string ph);
    @(posedge clk);
    #1;
    model_edge(load, en, 32'(seed));
    compare_all(ph);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string ph);
    #1;
    reset_n = 1'b0;
    #2;
    model_reset();
    compare_all(ph);
    #1;
    reset_n = 1'b1;
  endtask

  logic [4:0] fib_exp [6] = '{5'b10000, 5'b01000, 5'b00100, 5'b10010, 5'b01001, 5'b10100};
  logic [4:0] gal_exp [4] = '{5'b10100, 5'b01010, 5'b00101, 5'b10110};

  initial begin
    mdl[0].mode = 0; mdl[0].taps = 5'b00101; mdl[0].steps = 1;
    mdl[1].mode = 1; mdl[1].taps = 5'b10100; mdl[1].steps = 1;
    mdl[2].mode = 0; mdl[2].taps = 5'b00101; mdl[2].steps = 3;
    mdl[3].mode = 0; mdl[3].taps = 5'b00000; mdl[3].steps = 1;
    model_reset();

    // Reset state.
    #12;
    compare_all("reset");
    check("reset/fib_q", 32'(q_o[0]), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // First advances; async reset lands when fib q = 10010.
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle("seq");
      check("fib_seq", 32'(q_o[0]), 32'(fib_exp[c]));
      check("gal_seq", 32'(q_o[1]), 32'(gal_exp[c]));
      if (c == 0) begin
        check("ms3_q", 32'(q_o[2]), 32'b00100);
        check("ms3_count", 32'(count_o[2]), 32'd3);
        check("zero_lockup", 32'(lockup_o[3]), 32'd1);
        check("zero_q", 32'(q_o[3]), 32'd1);
      end
    end
    async_reset("mid_rst");
    check("mid_rst/fib_q", 32'(q_o[0]), 32'd1);
    check("mid_rst/fib_count", 32'(count_o[0]), 32'd0);
    check("mid_rst/fib_period", 32'(period_o[0]), 32'd0);

    // Full period from reset: wrap on the 31st advance.
    for (int c = 1; c <= 31; c++) begin
      cycle("wrap");
      if (c <= 6) check("fib_seq2", 32'(q_o[0]), 32'(fib_exp[c-1]));
      if (c == 30) check("fib_no_early_wrap", 32'(wrap_o[0]), 32'd0);
    end
    check("fib_wrap", 32'(wrap_o[0]), 32'd1);
    check("fib_wrap_q", 32'(q_o[0]), 32'd1);
    check("fib_period", 32'(period_o[0]), 32'd31);
    check("fib_count0", 32'(count_o[0]), 32'd0);
    check("ms3_wrap_q", 32'(q_o[2]), 32'd1);
    check("ms3_period", 32'(period_o[2]), 32'd31);

    // en low: hold, pulse drops.
    en = 1'b0;
    cycle("hold");
    check("fib_wrap_drop", 32'(wrap_o[0]), 32'd0);
    check("fib_hold_period", 32'(period_o[0]), 32'd31);

    // Seed loads.
    load = 1'b1; seed = 5'b01101;
    cycle("load");
    check("load_q", 32'(q_o[0]), 32'b01101);
    check("load_count", 32'(count_o[0]), 32'd0);
    en = 1'b1;
    cycle("load_en");
    check("load_en_q", 32'(q_o[0]), 32'b01101);
    check("load_en_count", 32'(count_o[0]), 32'd0);
    en = 1'b0; seed = 5'd0;
    cycle("load_zero");
    check("load_zero_q", 32'(q_o[0]), 32'd1);
    check("load_zero_lockup", 32'(lockup_o[0]), 32'd1);
    load = 1'b0;
    cycle("lockup_drop");
    check("lockup_drop", 32'(lockup_o[0]), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset("rnd_rst");
      end
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 11) == 0);
      seed = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
